// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing constants, also used by the sprite/prompt controllers.
package vga_pkg;

    localparam int unsigned CNT_W       = 10;
    localparam int unsigned FRAME_CNT_W = 8;

    localparam int unsigned VGA_CLK_DIV     = 4;
    localparam int unsigned VGA_H_TOTAL     = 800;
    localparam int unsigned VGA_H_SYNC      = 96;
    localparam int unsigned VGA_H_ACT_START = 144;
    localparam int unsigned VGA_H_ACT_END   = 784;
    localparam int unsigned VGA_V_TOTAL     = 525;
    localparam int unsigned VGA_V_SYNC      = 2;
    localparam int unsigned VGA_V_ACT_START = 35;
    localparam int unsigned VGA_V_ACT_END   = 515;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the pixel-consuming controllers.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic [CNT_W-1:0]       hCount;
    logic [CNT_W-1:0]       vCount;
    logic                   bright;
    logic                   hSync;
    logic                   vSync;
    logic                   pix_tick;
    logic                   frame_start;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    modport master (
        output hCount, vCount, bright, hSync, vSync, pix_tick, frame_start, frame_cnt
    );

    modport slave (
        input hCount, vCount, bright, hSync, vSync, pix_tick, frame_start, frame_cnt
    );

endinterface

// File: rtl/pixel_tick_div.sv
// System-clock divider: pix_tick is high for the last clock of every CLK_DIV-clock pixel period.
module pixel_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;

    // Tick is registered from the next divider value, so it equals (div == CLK_DIV-1) every cycle.
    always_comb begin
        div_d  = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
        tick_d = (div_d == DIV_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign pix_tick = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel divider, h/v counters, sync/blank decode, frame pulse and counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV     = VGA_CLK_DIV,
    parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_ACT_START = VGA_H_ACT_START,
    parameter int unsigned H_ACT_END   = VGA_H_ACT_END,
    parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_ACT_START = VGA_V_ACT_START,
    parameter int unsigned V_ACT_END   = VGA_V_ACT_END
) (
    input  logic                     clk,
    input  logic                     rst,
    vga_timing_gen_if.master         vga
);

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYN   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYN   = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_S = CNT_W'(H_ACT_START);
    localparam logic [CNT_W-1:0] H_ACT_E = CNT_W'(H_ACT_END);
    localparam logic [CNT_W-1:0] V_ACT_S = CNT_W'(V_ACT_START);
    localparam logic [CNT_W-1:0] V_ACT_E = CNT_W'(V_ACT_END);

    logic                   pix_tick;
    logic [CNT_W-1:0]       h_q, h_d;
    logic [CNT_W-1:0]       v_q, v_d;
    logic [FRAME_CNT_W-1:0] fc_q, fc_d;
    logic                   fs_q, fs_d;
    logic                   h_sync_q, h_sync_d;
    logic                   v_sync_q, v_sync_d;
    logic                   bright_q, bright_d;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_div (
        .clk      (clk),
        .rst      (rst),
        .pix_tick (pix_tick)
    );

    // Counter advance; sync/bright decode from next-state counts so they line up with the counts.
    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        fc_d = fc_q;
        fs_d = 1'b0;
        if (pix_tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d  = '0;
                    fc_d = fc_q + FRAME_CNT_W'(1);
                    fs_d = 1'b1;
                end else begin
                    v_d = v_q + CNT_W'(1);
                end
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
        h_sync_d = (h_d >= H_SYN);
        v_sync_d = (v_d >= V_SYN);
        bright_d = (h_d >= H_ACT_S) && (h_d < H_ACT_E) &&
                   (v_d >= V_ACT_S) && (v_d < V_ACT_E);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q      <= '0;
            v_q      <= '0;
            fc_q     <= '0;
            fs_q     <= 1'b0;
            h_sync_q <= 1'b0;
            v_sync_q <= 1'b0;
            bright_q <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            fc_q     <= fc_d;
            fs_q     <= fs_d;
            h_sync_q <= h_sync_d;
            v_sync_q <= v_sync_d;
            bright_q <= bright_d;
        end
    end

    assign vga.hCount      = h_q;
    assign vga.vCount      = v_q;
    assign vga.frame_cnt   = fc_q;
    assign vga.frame_start = fs_q;
    assign vga.hSync       = h_sync_q;
    assign vga.vSync       = v_sync_q;
    assign vga.bright      = bright_q;
    assign vga.pix_tick    = pix_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: full-size instance for reset/line behaviour, shrunken instance for frame and frame_cnt wrap.
module tb_vga_timing_gen;

    logic clk;
    logic rst_a;
    logic rst_b;

    int unsigned tests_run;
    int unsigned tests_failed;

    vga_timing_gen_if ifa ();
    vga_timing_gen_if ifb ();

    vga_timing_gen u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .vga (ifa)
    );

    // Small raster: 8x5 pixels, 160 clk per frame.
    vga_timing_gen #(
        .CLK_DIV     (4),
        .H_TOTAL     (8),
        .H_SYNC      (1),
        .H_ACT_START (2),
        .H_ACT_END   (6),
        .V_TOTAL     (5),
        .V_SYNC      (1),
        .V_ACT_START (1),
        .V_ACT_END   (4)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .vga (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [32:0] obs_a, obs_b;
    assign obs_a = {ifa.hCount, ifa.vCount, ifa.hSync, ifa.vSync, ifa.bright,
                    ifa.pix_tick, ifa.frame_start, ifa.frame_cnt};
    assign obs_b = {ifb.hCount, ifb.vCount, ifb.hSync, ifb.vSync, ifb.bright,
                    ifb.pix_tick, ifb.frame_start, ifb.frame_cnt};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected outputs n clock edges after reset release, from closed-form raster arithmetic.
    function automatic logic [32:0] expect_vec(
        input int unsigned n,  input int unsigned cd,
        input int unsigned ht, input int unsigned hs, input int unsigned has, input int unsigned hae,
        input int unsigned vt, input int unsigned vs, input int unsigned vas, input int unsigned vae);
        int unsigned px, line, h, v, fr;
        logic hsy, vsy, br, pt, fs;
        px   = n / cd;
        h    = px % ht;
        line = px / ht;
        v    = line % vt;
        fr   = line / vt;
        hsy  = (h >= hs);
        vsy  = (v >= vs);
        br   = (h >= has) && (h < hae) && (v >= vas) && (v < vae);
        pt   = ((n % cd) == cd - 1);
        fs   = (n != 0) && ((n % (cd * ht * vt)) == 0);
        return {10'(h), 10'(v), hsy, vsy, br, pt, fs, 8'(fr % 256)};
    endfunction

    function automatic logic [32:0] exp_a(input int unsigned n);
        return expect_vec(n, 4, 800, 96, 144, 784, 525, 2, 35, 515);
    endfunction

    function automatic logic [32:0] exp_b(input int unsigned n);
        return expect_vec(n, 4, 8, 1, 2, 6, 5, 1, 1, 4);
    endfunction

    initial begin
        int unsigned hsync_low;
        int unsigned fs_first;
        int unsigned fs_second;
        int unsigned fs_seen;

        tests_run    = 0;
        tests_failed = 0;
        rst_a        = 1'b0;
        rst_b        = 1'b0;

        // Reset held for 10 clk: everything zero on both instances
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("reset_a", 64'(obs_a), 64'd0);
        check("reset_b", 64'(obs_b), 64'd0);

        // Full-size instance: first line and a little of the second
        rst_a = 1'b1;
        #1;
        check("a_n0", 64'(obs_a), 64'(exp_a(0)));
        hsync_low = (ifa.hSync == 1'b0) ? 1 : 0;
        for (int n = 1; n <= 3300; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("a_n%0d", n), 64'(obs_a), 64'(exp_a(n)));
            if (n < 3200 && ifa.hSync == 1'b0) hsync_low++;
            if (n == 3) check("a_first_tick", 64'(ifa.pix_tick), 64'd1);
            if (n == 4) check("a_first_hcount", 64'(ifa.hCount), 64'd1);
            if (n == 7) check("a_second_tick", 64'(ifa.pix_tick), 64'd1);
            if (n == 383) check("a_hsync_last_low", 64'(ifa.hSync), 64'd0);
            if (n == 384) check("a_hsync_rise", 64'(ifa.hSync), 64'd1);
            if (n == 3199) check("a_line_end", 64'({ifa.hCount, ifa.vCount}), 64'({10'd799, 10'd0}));
            if (n == 3200) check("a_line_wrap", 64'({ifa.hCount, ifa.vCount}), 64'({10'd0, 10'd1}));
        end
        check("a_hsync_low_clks", 64'(hsync_low), 64'd384);
        rst_a = 1'b0;

        // Small instance: 257 frames to cover frame wrap and frame_cnt 255->0
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check("b_n0", 64'(obs_b), 64'(exp_b(0)));
        fs_seen   = 0;
        fs_first  = 0;
        fs_second = 0;
        for (int n = 1; n <= 41196; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("b_n%0d", n), 64'(obs_b), 64'(exp_b(n)));
            if (ifb.frame_start) begin
                if (fs_seen == 0) fs_first = n;
                if (fs_seen == 1) fs_second = n;
                fs_seen++;
            end
            case (n)
                8:     check("b_bright_h2v0", 64'(ifb.bright), 64'd0);
                36:    check("b_bright_h1v1", 64'(ifb.bright), 64'd0);
                40:    check("b_bright_h2v1", 64'(ifb.bright), 64'd1);
                116:   check("b_bright_h5v3", 64'(ifb.bright), 64'd1);
                120:   check("b_bright_h6v3", 64'(ifb.bright), 64'd0);
                159:   check("b_last_px", 64'({ifb.hCount, ifb.vCount}), 64'({10'd7, 10'd4}));
                160:   check("b_frame_wrap", 64'({ifb.hCount, ifb.vCount, ifb.frame_start, ifb.frame_cnt}),
                             64'({10'd0, 10'd0, 1'b1, 8'd1}));
                161:   check("b_fs_one_clk", 64'(ifb.frame_start), 64'd0);
                40800: check("b_fc_255", 64'(ifb.frame_cnt), 64'd255);
                40960: check("b_fc_wrap", 64'({ifb.frame_start, ifb.frame_cnt}), 64'({1'b1, 8'd0}));
                41196: check("b_pre_reset", 64'({ifb.hCount, ifb.vCount, ifb.bright, ifb.frame_cnt}),
                             64'({10'd3, 10'd2, 1'b1, 8'd1}));
                default: ;
            endcase
        end
        check("b_frame_period", 64'(fs_second - fs_first), 64'd160);
        check("b_frame_count", 64'(fs_seen), 64'd257);

        // Mid-frame reset off the clock edge: outputs clear before the next edge
        #2;
        rst_b = 1'b0;
        #1;
        check("b_async_reset", 64'(obs_b), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("b_held_reset", 64'(obs_b), 64'd0);
        rst_b = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("b_restart_n%0d", n), 64'(obs_b), 64'(exp_b(n)));
            if (n == 3) check("b_restart_tick", 64'(ifb.pix_tick), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
